sparam_sweep_ctrl: RTL and testbench

- Sequences an N-port S-parameter measurement across a frequency grid.
- For each frequency point and each source port, it enables the source, waits a settle time and averages 2^NAVG_LOG2 receiver samples on every port.
- It then streams one averaged word per receive port over a valid/ready interface.
- It sits between the stimulus/receiver front end and the result store; the generalised N-port, multi-point successor of the fixed 4-port, single-frequency coupler test.

---
 rtl/sparam_sweep_pkg.sv | 23 ++
 rtl/sparam_avg_acc.sv | 43 ++++
 rtl/sparam_sweep_ctrl.sv | 160 ++++++++++++++++
 tb/tb_sparam_sweep_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sparam_sweep_pkg.sv
// Shared state encoding and width helpers for the S-parameter sweep controller.
package sparam_sweep_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_ACQ,
    ST_DRAIN,
    ST_NEXT,
    ST_DONE
  } state_e;

  // Index width that still works for a single-entry range.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Growth of NAVG_LOG2 bits holds 2^NAVG_LOG2 full-scale samples without overflow.
  function automatic int acc_w(input int dw, input int navg_log2);
    return dw + navg_log2;
  endfunction

endpackage

// File: rtl/sparam_avg_acc.sv
// Bank of signed per-port accumulators with a shifted (averaged) read-back mux.
module sparam_avg_acc
  import sparam_sweep_pkg::*;
#(
  parameter int NPORTS    = 4,
  parameter int DW        = 16,
  parameter int NAVG_LOG2 = 2,
  localparam int PW       = idx_w(NPORTS),
  localparam int AW       = acc_w(DW, NAVG_LOG2)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clr_i,
  input  logic                   en_i,
  input  logic [NPORTS*DW-1:0]   smp_i,
  input  logic [PW-1:0]          rx_sel_i,
  output logic [DW-1:0]          res_o
);

  logic signed [AW-1:0] acc_q [NPORTS];
  logic signed [AW-1:0] sel_acc;

  always_ff @(posedge clk_i) begin
    for (int k = 0; k < NPORTS; k++) begin
      if (rst_i || clr_i) begin
        acc_q[k] <= '0;
      end else if (en_i) begin
        acc_q[k] <= acc_q[k] + AW'($signed(smp_i[k*DW +: DW]));
      end
    end
  end

  always_comb begin
    sel_acc = '0;
    for (int k = 0; k < NPORTS; k++) begin
      if (PW'(k) == rx_sel_i) sel_acc = acc_q[k];
    end
  end

  // Arithmetic shift floors toward -inf; the quotient always fits DW bits.
  assign res_o = DW'(sel_acc >>> NAVG_LOG2);

endmodule

// File: rtl/sparam_sweep_ctrl.sv
// Frequency x source sweep sequencer: settle, average receiver samples, stream results.
module sparam_sweep_ctrl
  import sparam_sweep_pkg::*;
#(
  parameter int NPORTS    = 4,
  parameter int NPTS      = 16,
  parameter int DW        = 16,
  parameter int NAVG_LOG2 = 2,
  parameter int SETTLE    = 8,
  localparam int PW       = idx_w(NPORTS),
  localparam int FW       = idx_w(NPTS),
  localparam int CW       = idx_w(SETTLE),
  localparam int NW       = idx_w(1 << NAVG_LOG2)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 src_en,
  output logic [PW-1:0]        src_port,
  output logic [FW-1:0]        freq_idx,
  input  logic                 smp_valid,
  input  logic [NPORTS*DW-1:0] smp_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DW-1:0]        out_data,
  output logic [PW-1:0]        out_rx,
  output logic [PW-1:0]        out_src,
  output logic [FW-1:0]        out_freq
);

  localparam logic [PW-1:0] LAST_SRC  = PW'(NPORTS - 1);
  localparam logic [FW-1:0] LAST_FREQ = FW'(NPTS - 1);
  localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE - 1);
  localparam logic [NW-1:0] NAVG_LD   = NW'((1 << NAVG_LOG2) - 1);

  state_e        state_q;
  logic [CW-1:0] settle_cnt_q;
  logic [NW-1:0] smp_cnt_q;
  logic [PW-1:0] rx_q;
  logic [PW-1:0] src_q;
  logic [FW-1:0] freq_q;
  logic          busy_q;
  logic          done_q;
  logic          src_en_q;
  logic          valid_q;
  logic          acc_clr;
  logic          acc_en;
  logic [DW-1:0] acc_res;

  // Accumulators are cleared on the last settle cycle so ACQ starts from zero.
  assign acc_clr = (state_q == ST_SETTLE) && (settle_cnt_q == '0);
  assign acc_en  = (state_q == ST_ACQ) && smp_valid;

  sparam_avg_acc #(
    .NPORTS   (NPORTS),
    .DW       (DW),
    .NAVG_LOG2(NAVG_LOG2)
  ) u_acc (
    .clk_i   (clk),
    .rst_i   (rst),
    .clr_i   (acc_clr),
    .en_i    (acc_en),
    .smp_i   (smp_data),
    .rx_sel_i(rx_q),
    .res_o   (acc_res)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      settle_cnt_q <= '0;
      smp_cnt_q    <= '0;
      rx_q         <= '0;
      src_q        <= '0;
      freq_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      src_en_q     <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q      <= ST_SETTLE;
            busy_q       <= 1'b1;
            src_en_q     <= 1'b1;
            src_q        <= '0;
            freq_q       <= '0;
            settle_cnt_q <= SETTLE_LD;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt_q == '0) begin
            state_q   <= ST_ACQ;
            smp_cnt_q <= NAVG_LD;
          end else begin
            settle_cnt_q <= settle_cnt_q - 1'b1;
          end
        end
        ST_ACQ: begin
          if (smp_valid) begin
            if (smp_cnt_q == '0) begin
              state_q <= ST_DRAIN;
              valid_q <= 1'b1;
              rx_q    <= '0;
            end else begin
              smp_cnt_q <= smp_cnt_q - 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (out_ready) begin
            if (rx_q == LAST_SRC) begin
              state_q  <= ST_NEXT;
              valid_q  <= 1'b0;
              rx_q     <= '0;
              src_en_q <= 1'b0;
            end else begin
              rx_q <= rx_q + 1'b1;
            end
          end
        end
        ST_NEXT: begin
          if (src_q == LAST_SRC) begin
            src_q  <= '0;
            freq_q <= (freq_q == LAST_FREQ) ? '0 : freq_q + 1'b1;
          end else begin
            src_q <= src_q + 1'b1;
          end
          if ((src_q == LAST_SRC) && (freq_q == LAST_FREQ)) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q      <= ST_SETTLE;
            src_en_q     <= 1'b1;
            settle_cnt_q <= SETTLE_LD;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign src_en    = src_en_q;
  assign src_port  = src_q;
  assign freq_idx  = freq_q;
  assign out_valid = valid_q;
  assign out_data  = valid_q ? acc_res : '0;
  assign out_rx    = rx_q;
  assign out_src   = src_q;
  assign out_freq  = freq_q;

endmodule

// File: tb/tb_sparam_sweep_ctrl.sv
// Self-checking bench: cycle-level behavioural sweep model, averaging table and corner sequences.
module tb_sparam_sweep_ctrl;

  localparam int NP = 2, NF = 2, DW = 8, NL = 1, ST = 3;
  localparam int NA = 1 << NL;
  localparam int PW = 1, FW = 1;
  localparam int M_IDLE = 0, M_SET = 1, M_ACQ = 2, M_DRAIN = 3, M_NEXT = 4, M_DONE = 5;

  logic clk = 1'b0;
  logic rst, start, smp_valid, out_ready;
  logic [NP*DW-1:0] smp_data;
  logic busy, done, src_en, out_valid;
  logic [PW-1:0] src_port, out_rx, out_src;
  logic [FW-1:0] freq_idx, out_freq;
  logic [DW-1:0] out_data;

  always #5 clk = ~clk;

  sparam_sweep_ctrl #(
    .NPORTS(NP), .NPTS(NF), .DW(DW), .NAVG_LOG2(NL), .SETTLE(ST)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .src_en(src_en), .src_port(src_port), .freq_idx(freq_idx),
    .smp_valid(smp_valid), .smp_data(smp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_rx(out_rx), .out_src(out_src), .out_freq(out_freq)
  );

  typedef struct { int data; int rx; int src; int frq; int midx; } word_t;
  typedef struct { int s0; int s1; int exp; } avg_vec_t;

  avg_vec_t tv[4];
  word_t    wq[$];
  int ph, cnt, need, msrc, mfrq, meas;
  int sum[NP];
  int nvec = 0, nerr = 0;
  int vmode, rmode, dmode, srand, cyc;
  int hs_cnt, done_cnt;

  function automatic int fdiv(input int a, input int b);
    return (a >= 0) ? a / b : -((-a + b - 1) / b);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    int v;
    case (vmode)
      0:       smp_valid = 1'b1;
      1:       smp_valid = 1'($urandom_range(0, 1));
      default: smp_valid = (cyc % 3 == 0);
    endcase
    for (int k = 0; k < NP; k++) begin
      case (dmode)
        0:       v = (k == 0) ? 10 : -4;
        1:       v = int'($urandom_range(0, 255)) - 128;
        default: v = (need == NA) ? tv[meas % 4].s0 : tv[meas % 4].s1;
      endcase
      smp_data[k*DW +: DW] = DW'(v);
    end
    case (rmode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
    if (srand != 0 && $urandom_range(0, 4) == 0) start = 1'b1;
  endtask

  // Reference model: advances one clock using the inputs the DUT just sampled.
  task automatic model_edge();
    word_t w;
    if (rst) begin
      ph = M_IDLE; msrc = 0; mfrq = 0; meas = 0; wq.delete();
      return;
    end
    case (ph)
      M_IDLE: if (start) begin
        ph = M_SET; cnt = ST; msrc = 0; mfrq = 0; meas = 0;
      end
      M_SET: begin
        cnt--;
        if (cnt == 0) begin
          ph = M_ACQ; need = NA;
          for (int k = 0; k < NP; k++) sum[k] = 0;
        end
      end
      M_ACQ: if (smp_valid) begin
        for (int k = 0; k < NP; k++) sum[k] += int'($signed(smp_data[k*DW +: DW]));
        need--;
        if (need == 0) begin
          for (int k = 0; k < NP; k++) begin
            w.data = fdiv(sum[k], NA); w.rx = k; w.src = msrc; w.frq = mfrq; w.midx = meas;
            wq.push_back(w);
          end
          meas++;
          ph = M_DRAIN;
        end
      end
      M_DRAIN: if (out_ready) begin
        void'(wq.pop_front());
        if (wq.size() == 0) ph = M_NEXT;
      end
      M_NEXT: begin
        if (msrc == NP - 1 && mfrq == NF - 1) begin
          ph = M_DONE; msrc = 0; mfrq = 0;
        end else begin
          if (msrc == NP - 1) begin msrc = 0; mfrq++; end
          else msrc++;
          ph = M_SET; cnt = ST;
        end
      end
      default: ph = M_IDLE;
    endcase
  endtask

  task automatic check_outputs();
    word_t w;
    chk("busy", int'(busy), int'(ph >= M_SET && ph <= M_NEXT));
    chk("done", int'(done), int'(ph == M_DONE));
    chk("src_en", int'(src_en), int'(ph >= M_SET && ph <= M_DRAIN));
    chk("src_port", int'(src_port), msrc);
    chk("freq_idx", int'(freq_idx), mfrq);
    chk("out_valid", int'(out_valid), int'(ph == M_DRAIN));
    if (ph == M_DRAIN) begin
      w = wq[0];
      chk("out_data", int'($signed(out_data)), w.data);
      chk("out_rx", int'(out_rx), w.rx);
      chk("out_src", int'(out_src), w.src);
      chk("out_freq", int'(out_freq), w.frq);
      if (dmode == 2) chk("tbl_avg", int'($signed(out_data)), tv[w.midx % 4].exp);
    end
  endtask

  task automatic step();
    drive();
    if (out_valid && out_ready) hs_cnt++;
    if (done) done_cnt++;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cyc++;
    check_outputs();
    start = 1'b0;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    step();
  endtask

  task automatic finish_sweep();
    bit ok = 0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      step();
      if (ph == M_IDLE) ok = 1;
    end
    if (!ok) begin
      nvec++; nerr++;
      $display("FAIL sweep_timeout: sweep did not complete within budget");
    end
  endtask

  task automatic wait_phase(input string name, input int p, input int f);
    bit ok = 0;
    for (int i = 0; i < 500 && !ok; i++) begin
      step();
      if (ph == p && (f < 0 || mfrq == f)) ok = 1;
    end
    if (!ok) begin
      nvec++; nerr++;
      $display("FAIL %s: phase not reached within budget", name);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_src_en"}, int'(src_en), 0);
    chk({tag, "_src_port"}, int'(src_port), 0);
    chk({tag, "_freq_idx"}, int'(freq_idx), 0);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_out_data"}, int'(out_data), 0);
    chk({tag, "_out_rx"}, int'(out_rx), 0);
    chk({tag, "_out_src"}, int'(out_src), 0);
    chk({tag, "_out_freq"}, int'(out_freq), 0);
  endtask

  initial begin
    int lat;
    tv[0] = '{s0: 3,    s1: 4,    exp: 3};
    tv[1] = '{s0: -3,   s1: -4,   exp: -4};
    tv[2] = '{s0: 127,  s1: 127,  exp: 127};
    tv[3] = '{s0: -128, s1: -127, exp: -128};

    ph = M_IDLE; cnt = 0; need = 0; msrc = 0; mfrq = 0; meas = 0;
    vmode = 0; rmode = 0; dmode = 0; srand = 0; cyc = 0;
    hs_cnt = 0; done_cnt = 0;
    rst = 1'b1; start = 1'b0; smp_valid = 1'b0; out_ready = 1'b0; smp_data = '0;

    step(); step();
    rst = 1'b0;
    chk_zero("reset");

    // Full sweep with constant inputs: latency, word count, single done pulse.
    hs_cnt = 0; done_cnt = 0;
    start_pulse();
    lat = 1;
    while (!out_valid && lat < 50) begin step(); lat++; end
    chk("first_latency", lat, 1 + ST + NA);
    finish_sweep();
    step();
    chk("full_words", hs_cnt, NP * NP * NF);
    chk("full_done_pulses", done_cnt, 1);

    // Averaging/rounding table, one entry per measurement.
    dmode = 2;
    start_pulse();
    finish_sweep();

    // Backpressure mid-drain with samples still streaming.
    dmode = 1; vmode = 0; rmode = 0;
    start_pulse();
    wait_phase("bp_reach_drain", M_DRAIN, -1);
    step();
    rmode = 2;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_valid", int'(out_valid), 1);
      chk("stall_rx", int'(out_rx), 1);
    end
    rmode = 0;
    finish_sweep();

    // Sparse strobes and random backpressure.
    vmode = 2; rmode = 1; dmode = 1;
    start_pulse();
    finish_sweep();

    // Reset in the middle of acquisition at frequency 1, then a clean rerun.
    vmode = 1; rmode = 0; hs_cnt = 0; done_cnt = 0;
    start_pulse();
    wait_phase("rst_reach_acq_f1", M_ACQ, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_zero("rst_mid");
    chk("rst_mid_no_done", done_cnt, 0);
    vmode = 0; dmode = 0; hs_cnt = 0; done_cnt = 0;
    start_pulse();
    finish_sweep();
    step();
    chk("rerun_words", hs_cnt, NP * NP * NF);
    chk("rerun_done_pulses", done_cnt, 1);

    // Starts while busy and in the DONE cycle are ignored; one cycle later it is taken.
    start_pulse();
    for (int i = 0; i < 6; i++) begin
      if (i == 4) start = 1'b1;
      step();
    end
    wait_phase("reach_done", M_DONE, -1);
    start = 1'b1;
    step();
    chk("start_in_done_ignored", int'(busy), 0);
    start = 1'b1;
    step();
    chk("start_after_done", int'(busy), 1);
    finish_sweep();

    // Fully randomized sweeps with stray start pulses.
    srand = 1; vmode = 1; rmode = 1; dmode = 1;
    for (int s = 0; s < 3; s++) begin
      start_pulse();
      finish_sweep();
    end
    srand = 0;
    for (int i = 0; i < 4; i++) step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
